// File: rtl/dma_rawp_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_rawp_stream_reader_if
// Description : Bundles the command, raw-port and TX-stream signals of the
//               raw-port stream reader.
//               slave  modport : the reader itself (DUT side)
//               master modport : command source, RAM raw port and consumer
//               Command : start_i, base_adr_i, len_i -> busy_o, done_o
//               Raw port: rawp_adr_o, rawp_dat_o, rawp_we_o <- rawp_dat_i,
//                         rawp_stall_i
//               Stream  : tx_data_o, tx_valid_o, tx_last_o <- tx_ready_i
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_rawp_stream_reader_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 16
) ();
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_adr_i;
    logic [LEN_WIDTH-1:0]  len_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] rawp_adr_o;
    logic [31:0]           rawp_dat_i;
    logic [31:0]           rawp_dat_o;
    logic                  rawp_we_o;
    logic                  rawp_stall_i;
    logic [7:0]            tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i;
    logic                  tx_last_o;

    modport slave (
        input  start_i, base_adr_i, len_i, rawp_dat_i, rawp_stall_i, tx_ready_i,
        output busy_o, done_o, rawp_adr_o, rawp_dat_o, rawp_we_o,
               tx_data_o, tx_valid_o, tx_last_o
    );

    modport master (
        output start_i, base_adr_i, len_i, rawp_dat_i, rawp_stall_i, tx_ready_i,
        input  busy_o, done_o, rawp_adr_o, rawp_dat_o, rawp_we_o,
               tx_data_o, tx_valid_o, tx_last_o
    );
endinterface
`default_nettype wire

// File: rtl/dma_rawp_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : dma_rawp_stream_reader
// Description : Reads a byte buffer through the 32-bit raw port of the DMA RAM
//               and serialises it little-endian onto an 8-bit valid/ready
//               stream. A one-word prefetch keeps the stream bubble-free.
// Ports       : clk_i  - clock (raw port of the RAM shares this net)
//               rst_i  - asynchronous active-high reset
//               bus    - command / raw-port / stream bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module dma_rawp_stream_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 16
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    dma_rawp_stream_reader_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state_q,   w_state_d;
    logic [ADDR_WIDTH-1:0] r_adr_q,     w_adr_d;
    logic [LEN_WIDTH-2:0]  r_words_q,   w_words_d;    // words still to fetch
    logic [LEN_WIDTH-1:0]  r_bytes_q,   w_bytes_d;    // bytes still to emit
    logic [31:0]           r_cur_q,     w_cur_d;
    logic                  r_cur_vld_q, w_cur_vld_d;
    logic [1:0]            r_idx_q,     w_idx_d;      // byte lane inside cur
    logic [31:0]           r_nxt_q,     w_nxt_d;
    logic                  r_nxt_vld_q, w_nxt_vld_d;

    logic [LEN_WIDTH-2:0]  w_len_words;
    logic                  w_rd;
    logic                  w_cap;
    logic                  w_tx_valid;
    logic                  w_hs;
    logic                  w_last;

    // ceil(len/4) without a wider intermediate sum
    assign w_len_words = {1'b0, bus.len_i[LEN_WIDTH-1:2]}
                       + {{(LEN_WIDTH-2){1'b0}}, |bus.len_i[1:0]};

    // A read is presented in LOAD, and in STREAM whenever the prefetch slot is
    // free and words remain. The RAM answers within the same cycle.
    assign w_rd       = (r_state_q == S_LOAD) ||
                        ((r_state_q == S_STREAM) && !r_nxt_vld_q && (r_words_q != '0));
    assign w_cap      = w_rd && !bus.rawp_stall_i;
    assign w_tx_valid = (r_state_q == S_STREAM) && r_cur_vld_q;
    assign w_hs       = w_tx_valid && bus.tx_ready_i;
    assign w_last     = (r_bytes_q == LEN_WIDTH'(1));

    always_comb begin
        w_state_d   = r_state_q;
        w_adr_d     = r_adr_q;
        w_words_d   = r_words_q;
        w_bytes_d   = r_bytes_q;
        w_cur_d     = r_cur_q;
        w_cur_vld_d = r_cur_vld_q;
        w_idx_d     = r_idx_q;
        w_nxt_d     = r_nxt_q;
        w_nxt_vld_d = r_nxt_vld_q;

        case (r_state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (bus.len_i != '0) begin
                        w_adr_d     = bus.base_adr_i;
                        w_words_d   = w_len_words;
                        w_bytes_d   = bus.len_i;
                        w_cur_vld_d = 1'b0;
                        w_nxt_vld_d = 1'b0;
                        w_idx_d     = 2'd0;
                        w_state_d   = S_LOAD;
                    end else begin
                        w_state_d   = S_DONE;
                    end
                end
            end

            S_LOAD: begin
                if (w_cap) begin
                    w_cur_d     = bus.rawp_dat_i;
                    w_cur_vld_d = 1'b1;
                    w_idx_d     = 2'd0;
                    w_adr_d     = r_adr_q + ADDR_WIDTH'(1);
                    w_words_d   = r_words_q - (LEN_WIDTH-1)'(1);
                    w_state_d   = S_STREAM;
                end
            end

            S_STREAM: begin
                if (w_cap) begin
                    w_nxt_d     = bus.rawp_dat_i;
                    w_nxt_vld_d = 1'b1;
                    w_adr_d     = r_adr_q + ADDR_WIDTH'(1);
                    w_words_d   = r_words_q - (LEN_WIDTH-1)'(1);
                end
                if (w_hs) begin
                    w_bytes_d = r_bytes_q - LEN_WIDTH'(1);
                    if (w_last) begin
                        // Unsent lanes of a trailing partial word are dropped.
                        w_cur_vld_d = 1'b0;
                        w_nxt_vld_d = 1'b0;
                        w_state_d   = S_DONE;
                    end else if (r_idx_q == 2'd3) begin
                        w_idx_d = 2'd0;
                        if (r_nxt_vld_q) begin
                            w_cur_d     = r_nxt_q;
                            w_nxt_vld_d = 1'b0;
                        end else if (w_cap) begin
                            // Word arrives exactly as cur drains: forward it.
                            w_cur_d     = bus.rawp_dat_i;
                            w_nxt_vld_d = 1'b0;
                        end else begin
                            w_cur_vld_d = 1'b0;
                            w_state_d   = S_LOAD;
                        end
                    end else begin
                        w_idx_d = r_idx_q + 2'd1;
                    end
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q   <= S_IDLE;
            r_adr_q     <= '0;
            r_words_q   <= '0;
            r_bytes_q   <= '0;
            r_cur_q     <= '0;
            r_cur_vld_q <= 1'b0;
            r_idx_q     <= 2'd0;
            r_nxt_q     <= '0;
            r_nxt_vld_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_adr_q     <= w_adr_d;
            r_words_q   <= w_words_d;
            r_bytes_q   <= w_bytes_d;
            r_cur_q     <= w_cur_d;
            r_cur_vld_q <= w_cur_vld_d;
            r_idx_q     <= w_idx_d;
            r_nxt_q     <= w_nxt_d;
            r_nxt_vld_q <= w_nxt_vld_d;
        end
    end

    assign bus.busy_o     = (r_state_q == S_LOAD) || (r_state_q == S_STREAM);
    assign bus.done_o     = (r_state_q == S_DONE);
    assign bus.rawp_adr_o = r_adr_q;
    assign bus.rawp_dat_o = 32'h0;
    assign bus.rawp_we_o  = 1'b0;
    assign bus.tx_valid_o = w_tx_valid;
    assign bus.tx_data_o  = w_tx_valid ? r_cur_q[{r_idx_q, 3'b000} +: 8] : 8'h00;
    assign bus.tx_last_o  = w_tx_valid && w_last;

endmodule
`default_nettype wire

// File: tb/tb_dma_rawp_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_rawp_stream_reader
// Description : Scoreboard bench for dma_rawp_stream_reader. Expected bytes
//               are derived from a word-array RAM model and queued when a
//               command is issued; a monitor consumes them on handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_rawp_stream_reader;
    localparam int AW = 9;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_rawp_stream_reader_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    dma_rawp_stream_reader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] mem [0:511];
    assign bus.rawp_dat_i = mem[bus.rawp_adr_o];

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx         = 0;
    int   exp_done       = 0;
    int   done_seen      = 0;
    int   hs_cnt         = 0;
    int   valid_rise_cyc = -1;
    int   done_cyc       = -1;
    int   errors         = 0;
    int   checks         = 0;
    int   cyc            = 0;
    int   start_cyc      = 0;

    int   rdy_mode  = 0;   // 0 held high, 1 toggle, 2 random
    int   rdy_pct   = 100;
    int   stl_mode  = 0;   // 0 none, 1 cycle window, 2 random
    int   stl_pct   = 0;
    int   stl_from  = 0;
    int   stl_to    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic       hold;
        logic       prev_valid;
        logic [7:0] prev_data;
        logic       prev_last;
        exp_t       e;
        hold = 1'b0;
        prev_valid = 1'b0;
        prev_data = 8'h00;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_idx     = exp_q.size();
                hold       = 1'b0;
                prev_valid = 1'b0;
            end else begin
                chk("rawp_write_tied", {bus.rawp_we_o, bus.rawp_dat_o[30:0]}, 32'h0);
                if (hold) begin
                    chk("hold_valid", {31'h0, bus.tx_valid_o}, 32'h1);
                    chk("hold_data", {24'h0, bus.tx_data_o}, {24'h0, prev_data});
                    chk("hold_last", {31'h0, bus.tx_last_o}, {31'h0, prev_last});
                end
                if (bus.tx_valid_o && !prev_valid) valid_rise_cyc = cyc;
                if (bus.tx_valid_o && bus.tx_ready_i) begin
                    hs_cnt++;
                    if (rd_idx >= exp_q.size()) begin
                        chk("unexpected_byte", {24'h0, bus.tx_data_o}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q[rd_idx];
                        rd_idx++;
                        chk("tx_data", {24'h0, bus.tx_data_o}, {24'h0, e.d});
                        chk("tx_last", {31'h0, bus.tx_last_o}, {31'h0, e.l});
                    end
                end
                if (bus.done_o) begin
                    done_seen++;
                    done_cyc = cyc;
                    chk("done_expected", {31'h0, (done_seen <= exp_done)}, 32'h1);
                    chk("bytes_before_done", rd_idx, exp_q.size());
                end
                hold       = bus.tx_valid_o && !bus.tx_ready_i;
                prev_valid = bus.tx_valid_o;
                prev_data  = bus.tx_data_o;
                prev_last  = bus.tx_last_o;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       bus.tx_ready_i = 1'b1;
            1:       bus.tx_ready_i = ~bus.tx_ready_i;
            default: bus.tx_ready_i = ($urandom_range(99) < rdy_pct);
        endcase
        case (stl_mode)
            0:       bus.rawp_stall_i = 1'b0;
            1:       bus.rawp_stall_i = (cyc >= stl_from) && (cyc < stl_to);
            default: bus.rawp_stall_i = ($urandom_range(99) < stl_pct);
        endcase
    endtask

    // Reference: byte k of the buffer is lane k%4 of word (base + k/4) mod 512.
    task automatic issue(input int base, input int len, input bit expect_done);
        exp_t e;
        logic [31:0] w;
        logic [AW-1:0] adr_before;
        for (int k = 0; k < len; k++) begin
            w   = mem[(base + k / 4) % 512];
            e.d = w[8 * (k % 4) +: 8];
            e.l = (k == len - 1);
            exp_q.push_back(e);
        end
        if (expect_done) exp_done++;
        adr_before = bus.rawp_adr_o;
        bus.start_i    = 1'b1;
        bus.base_adr_i = AW'(base);
        bus.len_i      = LW'(len);
        start_cyc      = cyc;
        step();
        bus.start_i    = 1'b0;
        bus.base_adr_i = AW'($urandom);
        bus.len_i      = LW'($urandom);
        if (len == 0) begin
            chk("len0_busy", {31'h0, bus.busy_o}, 32'h0);
            chk("len0_done", {31'h0, bus.done_o}, 32'h1);
            chk("len0_adr", {23'h0, bus.rawp_adr_o}, {23'h0, adr_before});
        end else begin
            chk("cycle1_busy", {31'h0, bus.busy_o}, 32'h1);
            chk("cycle1_adr", {23'h0, bus.rawp_adr_o}, base % 512);
        end
    endtask

    task automatic wait_done(input int budget, input bit restart);
        int n;
        n = 0;
        while (done_seen < exp_done && n < budget) begin
            if (restart && n == 3 && bus.busy_o) begin
                bus.start_i    = 1'b1;
                bus.base_adr_i = AW'($urandom);
                bus.len_i      = LW'($urandom_range(1, 30));
            end
            step();
            bus.start_i = 1'b0;
            n++;
        end
        chk("done_within_budget", done_seen, exp_done);
        if (done_seen < exp_done) begin
            rst = 1'b1;
            step();
            step();
            rst = 1'b0;
            exp_done = done_seen;
        end
    endtask

    task automatic preset_ram();
        for (int i = 0; i < 512; i++) mem[i] = i;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int hs0;
        int n;
        bus.start_i      = 1'b0;
        bus.base_adr_i   = '0;
        bus.len_i        = '0;
        bus.tx_ready_i   = 1'b1;
        bus.rawp_stall_i = 1'b0;
        preset_ram();

        #2;
        chk("reset_outputs",
            {bus.busy_o, bus.done_o, bus.rawp_we_o, bus.tx_valid_o, bus.tx_last_o,
             bus.tx_data_o, bus.rawp_adr_o},
            32'h0);
        chk("reset_rawp_dat", bus.rawp_dat_o, 32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // basic 8-byte transfer with cycle timing
        rdy_mode = 0; stl_mode = 0;
        issue(0, 8, 1'b1);
        wait_done(200, 1'b0);
        chk("first_valid_cycle", valid_rise_cyc - start_cyc, 2);
        chk("done_cycle", done_cyc - start_cyc, 10);

        // address wrap with trailing partial word
        issue(9'h1FF, 6, 1'b1);
        wait_done(200, 1'b0);

        // back-pressure toggling plus a raw-port stall window
        rdy_mode = 1;
        stl_mode = 1;
        stl_from = cyc + 3;
        stl_to   = cyc + 6;
        issue(10, 5, 1'b1);
        wait_done(200, 1'b0);
        rdy_mode = 0; stl_mode = 0;
        step();

        // zero length
        issue(0, 0, 1'b1);
        wait_done(50, 1'b0);

        // reset during the third byte
        hs0 = hs_cnt;
        issue(0, 8, 1'b0);
        n = 0;
        while (hs_cnt < hs0 + 2 && n < 50) begin
            step();
            n++;
        end
        chk("reached_third_byte", hs_cnt - hs0, 2);
        rst = 1'b1;
        #1;
        chk("abort_outputs",
            {bus.busy_o, bus.done_o, bus.rawp_we_o, bus.tx_valid_o, bus.tx_last_o,
             bus.tx_data_o, bus.rawp_adr_o},
            32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("no_done_after_abort", done_seen, exp_done);
        issue(0, 8, 1'b1);
        wait_done(200, 1'b0);
        chk("restart_first_valid", valid_rise_cyc - start_cyc, 2);
        chk("restart_done_cycle", done_cyc - start_cyc, 10);

        // start pulsed while busy must be ignored
        issue(3, 7, 1'b1);
        wait_done(200, 1'b1);

        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 512; i++) mem[i] = $urandom;
            rdy_mode = (t % 3 == 0) ? 0 : 2;
            rdy_pct  = $urandom_range(30, 100);
            stl_mode = (t % 2 == 0) ? 0 : 2;
            stl_pct  = $urandom_range(0, 50);
            n = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 20);
            issue($urandom_range(0, 511), n, 1'b1);
            wait_done(100 * n + 100, (t % 4 == 1));
            if ($urandom_range(1) == 1) step();
        end

        rdy_mode = 0; stl_mode = 0;
        step();
        step();
        chk("all_bytes_consumed", rd_idx, exp_q.size());
        chk("final_done_count", done_seen, exp_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_rawp_stream_reader.md
# dma_rawp_stream_reader

Read-side DMA engine for the raw port (port B) of the dual-port DMA RAM. It reads a byte-addressed buffer, which the CPU filled over Wishbone, through the 32-bit raw port. It then serialises the buffer into an 8-bit valid/ready byte stream for a transmit-side consumer such as a MAC TX or UART TX. Each transfer is started by a one-cycle command carrying a word base address and a byte length, and completion is reported with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_WIDTH, 9: raw-port word address width (9 = one 512x32 memory unit).
- LEN_WIDTH, 16: width of the byte-length field.

Ports:
- clk_i  in  1  single clock. The raw port of the RAM is clocked from this same net.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle command strobe. Sampled only in IDLE.
- base_adr_i  in  ADDR_WIDTH  word address of the first byte. Sampled with start_i.
- len_i  in  LEN_WIDTH  number of bytes to send. Sampled with start_i.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse at transfer end.
- rawp_adr_o  out  ADDR_WIDTH  raw-port word address.
- rawp_dat_i  in  32  raw-port read data.
- rawp_dat_o  out  32  raw-port write data. Tied to 0.
- rawp_we_o  out  1  raw-port write enable. Tied to 0.
- rawp_stall_i  in  1  raw-port stall. A word is not captured while this is high.
- tx_data_o  out  8  stream byte.
- tx_valid_o  out  1  byte valid.
- tx_ready_i  in  1  consumer ready.
- tx_last_o  out  1  marks the final byte of the transfer.

## Operation
- State machine has four states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - On start_i with len_i != 0: latch base and length, set the word counter to ceil(len_i/4), go to LOAD.
  - On start_i with len_i == 0: go directly to DONE. No raw-port reads and no bytes are produced.
- LOAD: present rawp_adr_o = current word address and capture rawp_dat_i at the end of the cycle.
  - The RAM's raw port is negedge-clocked, so an address driven from a register is read back within the same cycle.
  - If rawp_stall_i is high, keep the address and stay in LOAD.
  - On a successful capture, go to STREAM.
- Buffering: a two-word buffer, made of a current word (cur) and a prefetch word (nxt) with a valid flag.
  - In STREAM, while nxt is empty and words remain, issue one read per cycle into nxt. Stall retry rules are the same as in LOAD.
  - When byte index 3 of cur is handshaken, nxt moves into cur, or the block returns to LOAD if nxt is empty.
- Byte order is little-endian, matching Wishbone byte-lane order: byte 0 = bits [7:0], byte 3 = bits [31:24].
- Word address increments by 1 per word fetched and wraps modulo 2^ADDR_WIDTH. Wrapping is not an error.
- Byte counter decrements on each handshake (tx_valid_o & tx_ready_i). tx_last_o is high when the byte counter equals 1.
- A trailing partial word is read in full, but only its low (len mod 4) bytes are emitted.
- DONE: lasts one cycle with done_o = 1, then returns to IDLE.
- start_i outside IDLE is ignored.

## Timing
- Reset values:
  - All outputs are 0: busy_o, done_o, rawp_adr_o, rawp_dat_o, rawp_we_o, tx_data_o, tx_valid_o, tx_last_o.
  - State is IDLE and all counters are cleared.
- Reset asserted mid-transfer aborts immediately. The partial stream is dropped, no done_o is produced, and the block restarts from IDLE.
- Cycle-level sequence:
  - start_i in cycle 0.
  - busy_o and rawp_adr_o = base in cycle 1.
  - Word captured at the end of cycle 1.
  - tx_valid_o high from cycle 2 (no stalls).
- With tx_ready_i held high and no stalls, throughput is 1 byte per cycle with no bubbles at word boundaries, thanks to the prefetch.
- Stream handshake rules:
  - Once tx_valid_o rises, tx_data_o and tx_last_o stay stable and tx_valid_o stays high until the handshake.
  - tx_valid_o never depends combinationally on tx_ready_i.
- done_o pulses in the cycle after the handshake of the last byte. busy_o falls in that same cycle.
- len_i = 0: done_o in cycle 1, busy_o stays 0.
- Simultaneous events:
  - A stall during prefetch only delays nxt and never blocks the stream.
  - A handshake of byte 3 in the same cycle as the nxt capture forwards rawp_dat_i directly into cur.

## Test plan
- RAM preset to word n = n, base = 0, len = 8, tx_ready held 1:
  - bytes 00 00 00 00 01 00 00 00 on cycles 2..9.
  - tx_last on the 8th byte.
  - done_o on cycle 10.
  - rawp_we_o = 0 throughout.
- base = 0x1FF, len = 6: words 0x1FF then 0x000 are read (address wrap). Bytes FF 01 00 00 00 00; the last 2 bytes of word 0 are not emitted.
- len = 5, tx_ready toggling 1-0-1-0, rawp_stall high for 3 cycles mid-transfer: exactly 5 bytes in order, tx_data held stable while valid && !ready, a single done_o.
- len = 0: done_o one cycle after start, no tx_valid_o, no raw-port address change.
- rst_i asserted during the 3rd byte: all outputs 0 immediately, no done_o. A new start then behaves as in scenario 1.
- start_i pulsed again while busy: ignored, and the byte count and order of the running transfer are unchanged.
